// File: rtl/bcd_time_of_day.sv
// 24-hour BCD HH:MM:SS counter with a 1 s prescaler and a validated HH:MM load.
// Optional build macro FAST_TICK_EN: no prescaler, and every run cycle is a 1 s step.
module bcd_time_of_day #(
  parameter int CLK_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       set_valid,
  input  logic [3:0] set_hMSD,
  input  logic [3:0] set_hLSD,
  input  logic [3:0] set_mMSD,
  input  logic [3:0] set_mLSD,
  output logic [3:0] hMSD,
  output logic [3:0] hLSD,
  output logic [3:0] mMSD,
  output logic [3:0] mLSD,
  output logic [3:0] sMSD,
  output logic [3:0] sLSD,
  output logic       sec_tick,
  output logic       hour_tick,
  output logic       set_err
);

  logic       set_ok;
  logic       set_load;
  logic       step;
  logic       rollover;
  logic [3:0] nxt_hMSD, nxt_hLSD, nxt_mMSD, nxt_mLSD, nxt_sMSD, nxt_sLSD;

  // Hours 20-23 are the only legal values with a tens digit of 2.
  always_comb begin
    set_ok = (set_hMSD <= 4'd2) && (set_hLSD <= 4'd9) &&
             ((set_hMSD != 4'd2) || (set_hLSD <= 4'd3)) &&
             (set_mMSD <= 4'd5) && (set_mLSD <= 4'd9);
  end

  assign set_load = set_valid && set_ok;

`ifdef FAST_TICK_EN
  assign step = run;
`else
  localparam int PW = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_PER_SEC - 1);

  logic [PW-1:0] presc;

  assign step = run && (presc == LAST);

  // A valid load restarts the second; run=0 freezes the count mid-second.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (set_load) begin
      presc <= '0;
    end else if (run) begin
      if (presc == LAST) begin
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end
`endif

  assign rollover = (sLSD == 4'd9) && (sMSD == 4'd5) &&
                    (mLSD == 4'd9) && (mMSD == 4'd5);

  // Full ripple carry from seconds through hours, resolved in one cycle.
  always_comb begin
    nxt_hMSD = hMSD;
    nxt_hLSD = hLSD;
    nxt_mMSD = mMSD;
    nxt_mLSD = mLSD;
    nxt_sMSD = sMSD;
    nxt_sLSD = sLSD;
    if (sLSD != 4'd9) begin
      nxt_sLSD = sLSD + 4'd1;
    end else begin
      nxt_sLSD = 4'd0;
      if (sMSD != 4'd5) begin
        nxt_sMSD = sMSD + 4'd1;
      end else begin
        nxt_sMSD = 4'd0;
        if (mLSD != 4'd9) begin
          nxt_mLSD = mLSD + 4'd1;
        end else begin
          nxt_mLSD = 4'd0;
          if (mMSD != 4'd5) begin
            nxt_mMSD = mMSD + 4'd1;
          end else begin
            nxt_mMSD = 4'd0;
            if ((hMSD == 4'd2) && (hLSD == 4'd3)) begin
              nxt_hMSD = 4'd0;
              nxt_hLSD = 4'd0;
            end else if (hLSD == 4'd9) begin
              nxt_hMSD = hMSD + 4'd1;
              nxt_hLSD = 4'd0;
            end else begin
              nxt_hLSD = hLSD + 4'd1;
            end
          end
        end
      end
    end
  end

  // A valid load wins over a coincident step, so that second is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hMSD      <= 4'd0;
      hLSD      <= 4'd0;
      mMSD      <= 4'd0;
      mLSD      <= 4'd0;
      sMSD      <= 4'd0;
      sLSD      <= 4'd0;
      sec_tick  <= 1'b0;
      hour_tick <= 1'b0;
      set_err   <= 1'b0;
    end else if (set_load) begin
      hMSD      <= set_hMSD;
      hLSD      <= set_hLSD;
      mMSD      <= set_mMSD;
      mLSD      <= set_mLSD;
      sMSD      <= 4'd0;
      sLSD      <= 4'd0;
      sec_tick  <= 1'b0;
      hour_tick <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      set_err   <= set_valid;
      sec_tick  <= step;
      hour_tick <= step && rollover;
      if (step) begin
        hMSD <= nxt_hMSD;
        hLSD <= nxt_hLSD;
        mMSD <= nxt_mMSD;
        mLSD <= nxt_mLSD;
        sMSD <= nxt_sMSD;
        sLSD <= nxt_sLSD;
      end
    end
  end

endmodule

// File: tb/tb_bcd_time_of_day.sv
// Directed bench for bcd_time_of_day with CLK_PER_SEC=4 (prescaled build).
module tb_bcd_time_of_day;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       run;
  logic       set_valid;
  logic [3:0] set_hMSD, set_hLSD, set_mMSD, set_mLSD;
  logic [3:0] hMSD, hLSD, mMSD, mLSD, sMSD, sLSD;
  logic       sec_tick, hour_tick, set_err;

  int vectors = 0;
  int miscompares = 0;
  int hour_count;
  int bad_hour;
  int sec_count;

  bcd_time_of_day #(.CLK_PER_SEC(4)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .set_valid(set_valid),
    .set_hMSD(set_hMSD), .set_hLSD(set_hLSD), .set_mMSD(set_mMSD), .set_mLSD(set_mLSD),
    .hMSD(hMSD), .hLSD(hLSD), .mMSD(mMSD), .mLSD(mLSD), .sMSD(sMSD), .sLSD(sLSD),
    .sec_tick(sec_tick), .hour_tick(hour_tick), .set_err(set_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] now();
    return {8'h00, hMSD, hLSD, mMSD, mLSD, sMSD, sLSD};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] hhmm);
    set_valid = 1'b1;
    {set_hMSD, set_hLSD, set_mMSD, set_mLSD} = hhmm;
    step(1);
    set_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    run = 1'b1;
    set_valid = 1'b0;
    {set_hMSD, set_hLSD, set_mMSD, set_mLSD} = 16'h0000;
    step(2);
    checkOutput("reset_time", now(), 32'h000000);
    checkOutput("reset_pulses", {29'd0, sec_tick, hour_tick, set_err}, 32'd0);
    reset_n = 1'b1;

    // first second after reset
    step(3);
    checkOutput("no_tick_before_4th", {31'd0, sec_tick}, 32'd0);
    step(1);
    checkOutput("first_tick", {31'd0, sec_tick}, 32'd1);
    checkOutput("first_second", now(), 32'h000001);
    step(1);
    checkOutput("tick_one_cycle", {31'd0, sec_tick}, 32'd0);
    step(35);
    checkOutput("ten_seconds", now(), 32'h000010);

    // midnight rollover from 23:59
    applyStimulus(16'h2359);
    checkOutput("set_2359", now(), 32'h235900);
    checkOutput("set_no_tick", {30'd0, sec_tick, hour_tick}, 32'd0);
    hour_count = 0;
    bad_hour = 0;
    for (int i = 0; i < 239; i++) begin
      step(1);
      if (hour_tick) hour_count++;
    end
    checkOutput("at_235959", now(), 32'h235959);
    step(1);
    if (hour_tick) hour_count++;
    if (hour_tick && !sec_tick) bad_hour++;
    checkOutput("midnight", now(), 32'h000000);
    checkOutput("midnight_hour_tick", {31'd0, hour_tick}, 32'd1);
    checkOutput("hour_tick_count", hour_count, 32'd1);
    checkOutput("hour_tick_coincident", bad_hour, 32'd0);

    // invalid sets are rejected, counting continues
    applyStimulus(16'h2400);
    checkOutput("err_2400", {31'd0, set_err}, 32'd1);
    checkOutput("time_after_2400", now(), 32'h000000);
    applyStimulus(16'h1260);
    checkOutput("err_1260", {31'd0, set_err}, 32'd1);
    applyStimulus(16'h3000);
    checkOutput("err_3000", {31'd0, set_err}, 32'd1);
    step(1);
    checkOutput("err_one_cycle", {31'd0, set_err}, 32'd0);
    checkOutput("counting_after_err", now(), 32'h000001);
    checkOutput("tick_after_err", {31'd0, sec_tick}, 32'd1);

    // set in the terminal cycle drops that increment
    step(3);
    applyStimulus(16'h0730);
    checkOutput("set_on_terminal", now(), 32'h073000);
    checkOutput("set_on_terminal_tick", {31'd0, sec_tick}, 32'd0);
    step(3);
    checkOutput("no_early_tick", {31'd0, sec_tick}, 32'd0);
    step(1);
    checkOutput("tick_after_set", {31'd0, sec_tick}, 32'd1);
    checkOutput("time_after_set", now(), 32'h073001);

    // run=0 freezes digits and prescaler
    step(2);
    run = 1'b0;
    sec_count = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (sec_tick) sec_count++;
    end
    checkOutput("frozen_time", now(), 32'h073001);
    checkOutput("frozen_ticks", sec_count, 32'd0);
    run = 1'b1;
    step(1);
    checkOutput("resume_no_tick", {31'd0, sec_tick}, 32'd0);
    step(1);
    checkOutput("resume_tick", {31'd0, sec_tick}, 32'd1);
    checkOutput("resume_time", now(), 32'h073002);

    // set while stopped holds until run returns
    run = 1'b0;
    applyStimulus(16'h1234);
    step(5);
    checkOutput("set_while_stopped", now(), 32'h123400);
    run = 1'b1;
    step(4);
    checkOutput("run_after_stopped_set", now(), 32'h123401);

    // asynchronous reset mid-second
    step(2);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset", now(), 32'h000000);
    step(1);
    reset_n = 1'b1;
    step(4);
    checkOutput("after_reset_tick", now(), 32'h000001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
